// File: rtl/prbs8_pkg.sv
// Shared definitions for the 8-bit Fibonacci PRBS generator and checker.
// Polynomial taps are 6, 5, 4 and 0 of a right-shifting register.
package prbs8_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'b0111_0001;

  typedef enum logic [1:0] {
    StSeed,
    StVerify,
    StLocked
  } prbs8_state_e;

endpackage

// File: rtl/prbs8_predict.sv
// Next-bit predictor for the PRBS8 sequence: XOR of the tapped history bits.
// Purely combinational; usable on both generator and checker side.
module prbs8_predict
  import prbs8_pkg::*;
(
  input  logic [LFSR_W-1:0] hist,
  output logic              pred
);

  assign pred = ^(hist & TAP_MASK);

endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising PRBS8 receive checker with lock detection and error counting.
// Optional macro PRBS8_CHECKER_BITCNT_EN adds a locked-bit counter output (bit_count).
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count
`ifdef PRBS8_CHECKER_BITCNT_EN
  ,
  output logic [CNT_W-1:0] bit_count
`endif
);

  prbs8_state_e      state_q;
  logic [LFSR_W-1:0] hist_q;
  logic [2:0]        seed_cnt_q;
  logic [7:0]        match_cnt_q;
  logic [3:0]        miss_cnt_q;
  logic              locked_q;
  logic              bit_err_q;
  logic [CNT_W-1:0]  err_count_q;
  logic              pred;

  prbs8_predict u_predict (
    .hist (hist_q),
    .pred (pred)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StSeed;
      hist_q      <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      bit_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      bit_err_q <= 1'b0;
      if (clr_cnt) begin
        err_count_q <= '0;
      end
      if (bit_valid) begin
        unique case (state_q)
          StSeed: begin
            hist_q <= {bit_in, hist_q[LFSR_W-1:1]};
            if (seed_cnt_q == 3'd7) begin
              seed_cnt_q  <= '0;
              match_cnt_q <= '0;
              state_q     <= StVerify;
            end else begin
              seed_cnt_q <= seed_cnt_q + 3'd1;
            end
          end
          StVerify: begin
            hist_q <= {bit_in, hist_q[LFSR_W-1:1]};
            // An all-zero history is the LFSR's lock-up state and must never qualify.
            if ((bit_in == pred) && (hist_q != '0)) begin
              match_cnt_q <= match_cnt_q + 8'd1;
              if (match_cnt_q == 8'(LOCK_CNT - 1)) begin
                state_q    <= StLocked;
                locked_q   <= 1'b1;
                miss_cnt_q <= '0;
              end
            end else begin
              match_cnt_q <= '0;
            end
          end
          StLocked: begin
            // Flywheel: feed back our own prediction so line errors do not propagate.
            hist_q <= {pred, hist_q[LFSR_W-1:1]};
            if (bit_in != pred) begin
              bit_err_q <= 1'b1;
              if (!clr_cnt && (err_count_q != '1)) begin
                err_count_q <= err_count_q + CNT_W'(1);
              end
              if (miss_cnt_q == 4'(LOSS_THRESH - 1)) begin
                state_q    <= StSeed;
                locked_q   <= 1'b0;
                seed_cnt_q <= '0;
                miss_cnt_q <= '0;
                hist_q     <= '0;
              end else begin
                miss_cnt_q <= miss_cnt_q + 4'd1;
              end
            end else begin
              miss_cnt_q <= '0;
            end
          end
          default: state_q <= StSeed;
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign bit_err   = bit_err_q;
  assign err_count = err_count_q;

`ifdef PRBS8_CHECKER_BITCNT_EN
  logic [CNT_W-1:0] bit_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= '0;
    end else if (clr_cnt) begin
      bit_cnt_q <= '0;
    end else if (bit_valid && (state_q == StLocked) && (bit_cnt_q != '1)) begin
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

  assign bit_count = bit_cnt_q;
`else
  // No BER denominator in this build.
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker: a sequence-level model checked every cycle,
// plus literal expectations for lock latency, error counts and saturation.
module tb_prbs8_checker;

  localparam int LockCnt    = 16;
  localparam int LossThresh = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, bit_err, locked4, bit_err4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
`ifdef PRBS8_CHECKER_BITCNT_EN
  logic [15:0] bit_count;
  logic [3:0]  bit_count4;
`endif

  prbs8_checker dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .bit_err   (bit_err),
    .err_count (err_count)
`ifdef PRBS8_CHECKER_BITCNT_EN
    ,
    .bit_count (bit_count)
`endif
  );

  prbs8_checker #(.CNT_W(4)) dut4 (
    .clock     (clock),
    .reset_n   (reset_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked4),
    .bit_err   (bit_err4),
    .err_count (err_count4)
`ifdef PRBS8_CHECKER_BITCNT_EN
    ,
    .bit_count (bit_count4)
`endif
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  int n_pulse = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: the received sequence obeys s[t] = s[t-8]^s[t-4]^s[t-3]^s[t-2].
  bit   hq[$];
  int   phase;  // 0 seeding, 1 verifying, 2 locked
  int   n_seed, run, miss;
  bit   exp_locked, exp_err;
  int   exp_cnt, exp_cnt4, exp_bc, exp_bc4;
  logic [7:0] gen;

  function automatic bit gen_next();
    bit b;
    b   = gen[0];
    gen = {gen[6] ^ gen[5] ^ gen[4] ^ gen[0], gen[7:1]};
    return b;
  endfunction

  function automatic bit seq_next();
    return hq[0] ^ hq[4] ^ hq[5] ^ hq[6];
  endfunction

  task automatic push(input bit b);
    hq.push_back(b);
    if (hq.size() > 8) void'(hq.pop_front());
  endtask

  task automatic model_reset();
    hq.delete();
    phase = 0; n_seed = 0; run = 0; miss = 0;
    exp_locked = 1'b0; exp_err = 1'b0;
    exp_cnt = 0; exp_cnt4 = 0; exp_bc = 0; exp_bc4 = 0;
  endtask

  task automatic model_edge(input bit bv, input bit b, input bit clr);
    bit p, nz;
    exp_err = 1'b0;
    if (clr) begin
      exp_cnt = 0; exp_cnt4 = 0; exp_bc = 0; exp_bc4 = 0;
    end
    if (bv) begin
      case (phase)
        0: begin
          push(b);
          n_seed++;
          if (n_seed == 8) begin phase = 1; run = 0; end
        end
        1: begin
          p  = seq_next();
          nz = 1'b0;
          foreach (hq[i]) nz |= hq[i];
          push(b);
          if (b == p && nz) run++;
          else run = 0;
          if (run == LockCnt) begin phase = 2; miss = 0; end
        end
        default: begin
          p = seq_next();
          push(p);
          if (!clr) begin
            if (exp_bc < 65535) exp_bc++;
            if (exp_bc4 < 15) exp_bc4++;
          end
          if (b != p) begin
            exp_err = 1'b1;
            if (!clr) begin
              if (exp_cnt < 65535) exp_cnt++;
              if (exp_cnt4 < 15) exp_cnt4++;
            end
            miss++;
            if (miss == LossThresh) begin
              phase = 0; n_seed = 0; hq.delete();
            end
          end else begin
            miss = 0;
          end
        end
      endcase
    end
    exp_locked = (phase == 2);
  endtask

  task automatic step(input bit bv, input bit b, input bit clr);
    bit_valid = bv;
    bit_in    = b;
    clr_cnt   = clr;
    @(posedge clock);
    model_edge(bv, b, clr);
    #1;
    bit_valid = 1'b0;
    clr_cnt   = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    model_reset();
    #2 reset_n = 1'b1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("locked", 32'(locked), 32'(exp_locked));
      chk("bit_err", 32'(bit_err), 32'(exp_err));
      chk("err_count", 32'(err_count), exp_cnt);
      chk("locked4", 32'(locked4), 32'(exp_locked));
      chk("bit_err4", 32'(bit_err4), 32'(exp_err));
      chk("err_count4", 32'(err_count4), exp_cnt4);
`ifdef PRBS8_CHECKER_BITCNT_EN
      chk("bit_count", 32'(bit_count), exp_bc);
      chk("bit_count4", 32'(bit_count4), exp_bc4);
`endif
      if (bit_err) n_pulse++;
    end
  end

  initial begin
    int         lock_at;
    int         nvalid;
    logic [15:0] seq16;
    bit         b;
    bit         bv;

    model_reset();
    #3;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_bit_err", 32'(bit_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    #9 reset_n = 1'b1;

    // Pin the generator: first 16 bits from seed 8'h01.
    gen = 8'h01;
    for (int i = 0; i < 16; i++) seq16[i] = gen_next();
    chk("gen_seq16", 32'(seq16), 32'h8D01);
    gen = 8'h01;

    // Lock, then a single error on bit 40.
    lock_at = 0;
    for (int i = 1; i <= 40; i++) begin
      b = gen_next();
      if (i == 40) b = ~b;
      step(1'b1, b, 1'b0);
      if (locked === 1'b1 && lock_at == 0) lock_at = i;
    end
    chk("lock_bits", lock_at, 24);
    repeat (8) step(1'b1, gen_next(), 1'b0);
    chk("single_err_cnt", 32'(err_count), 1);
    chk("single_err_lock", 32'(locked), 1);
    chk("single_err_pulses", n_pulse, 1);

    // Clear without an error.
    step(1'b1, gen_next(), 1'b1);
    chk("clr_noerr", 32'(err_count), 0);

    // Four consecutive errors drop lock.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, ~gen_next(), 1'b0);
      if (k == 2) chk("loss_still_locked", 32'(locked), 1);
    end
    chk("loss_cnt", 32'(err_count), 4);
    chk("loss_lock", 32'(locked), 0);

    lock_at = 0;
    for (int i = 1; i <= 40 && lock_at == 0; i++) begin
      step(1'b1, gen_next(), 1'b0);
      if (locked === 1'b1) lock_at = i;
    end
    chk("relock_bits", lock_at, 24);

    // Clear coinciding with a counted error.
    step(1'b1, ~gen_next(), 1'b1);
    chk("clr_err_cnt", 32'(err_count), 0);
    chk("clr_err_pulse", 32'(bit_err), 1);
    repeat (3) step(1'b1, gen_next(), 1'b0);

    // 20 isolated errors: 4-bit counter saturates, 16-bit does not.
    for (int e = 0; e < 20; e++) begin
      step(1'b1, ~gen_next(), 1'b0);
      repeat (3) step(1'b1, gen_next(), 1'b0);
    end
    chk("sat4", 32'(err_count4), 15);
    chk("sat16", 32'(err_count), 20);
    chk("sat_locked", 32'(locked), 1);

    // Asynchronous reset right after an error edge.
    step(1'b1, ~gen_next(), 1'b0);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_locked", 32'(locked), 0);
    chk("arst_bit_err", 32'(bit_err), 0);
    chk("arst_err_count", 32'(err_count), 0);
    #1 reset_n = 1'b1;
    lock_at = 0;
    for (int i = 1; i <= 40 && lock_at == 0; i++) begin
      step(1'b1, gen_next(), 1'b0);
      if (locked === 1'b1) lock_at = i;
    end
    chk("arst_relock_bits", lock_at, 24);

    // Random valid gaps: lock still after exactly 24 valid bits.
    do_reset();
    lock_at = 0;
    nvalid  = 0;
    for (int c = 0; c < 300 && lock_at == 0; c++) begin
      bv = 1'($urandom_range(0, 1));
      if (bv) begin
        b = gen_next();
        nvalid++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      step(bv, b, 1'b0);
      if (locked === 1'b1) lock_at = nvalid;
    end
    chk("gap_lock_bits", lock_at, 24);

    // All-zero stream never locks.
    do_reset();
    repeat (100) step(1'b1, 1'b0, 1'b0);
    chk("zeros_lock", 32'(locked), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
